// File: rtl/core_pkg.sv
// core_pkg: shared LETC core types and constants used by the fetch stage.
package core_pkg;
    typedef logic [31:0] word_t;

    localparam word_t RESET_PC = 32'h00000000;
    localparam word_t PC_INCR  = 32'd4;

    typedef enum logic [1:0] {FETCH, FULL, SQUASH, FAULT} fetch_state_e;

    typedef struct packed {
        word_t addr;
        logic  valid;
    } mmu_instr_req_s;

    typedef struct packed {
        word_t data;
        logic  ready;
        logic  illegal;
    } mmu_instr_rsp_s;

    typedef struct packed {
        logic  valid;
        word_t pc;
        word_t instr;
    } s1_to_s2_s;

    typedef struct packed {
        logic  branch_en;
        word_t branch_target_addr;
    } s2_to_s1_s;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  fault;
    } fetch_entry_s;
endpackage

// File: rtl/core_fetch_skid.sv
// core_fetch_skid: one-entry holding register between the icache and the s2 output register.
module core_fetch_skid import core_pkg::*; (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_s i_entry,
    output logic         o_valid,
    output fetch_entry_s o_entry
);
    logic         valid_d, valid_q;
    fetch_entry_s entry_d, entry_q;

    always_comb begin
        valid_d = i_flush ? 1'b0 : i_push ? 1'b1 : i_pop ? 1'b0 : valid_q;
        entry_d = i_push ? i_entry : entry_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign o_valid = valid_q;
    assign o_entry = entry_q;
endmodule

// File: rtl/core_fetch_ctrl.sv
// core_fetch_ctrl: stage-1 fetch sequencer; owns the PC, drives icache requests,
// presents fetched instructions to s2 and applies s2 redirects.
module core_fetch_ctrl import core_pkg::*; #(
    parameter word_t RESET_PC = core_pkg::RESET_PC
) (
    input  logic           i_clk,
    input  logic           i_rst,
    output mmu_instr_req_s o_instr_req,
    input  mmu_instr_rsp_s i_instr_rsp,
    output s1_to_s2_s      o_s1_to_s2,
    output logic           o_fetch_fault,
    input  logic           i_stall,
    input  s2_to_s1_s      i_s2_to_s1
);
    fetch_state_e state_d, state_q;
    word_t        fetch_pc_d, fetch_pc_q, squash_addr_d, squash_addr_q;
    logic         out_valid_d, out_valid_q;
    fetch_entry_s out_d, out_q, cap_entry, skid_entry;
    logic         skid_valid, redirect, req_valid, done, cap, consume, load_out, push, pop;

    core_fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (redirect),
        .i_entry (cap_entry),
        .o_valid (skid_valid),
        .o_entry (skid_entry)
    );

    always_comb begin
        redirect  = i_s2_to_s1.branch_en;
        req_valid = !i_rst && (state_q == FETCH || state_q == SQUASH);
        done      = req_valid && i_instr_rsp.ready;
        cap       = state_q == FETCH && done && !redirect;
        consume   = out_valid_q && !i_stall;
        load_out  = !out_valid_q || consume;
        pop       = load_out && skid_valid;
        push      = cap && !(load_out && !skid_valid);
        cap_entry = '{pc: fetch_pc_q, instr: i_instr_rsp.data, fault: i_instr_rsp.illegal};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            squash_addr_q <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_q         <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            squash_addr_q <= squash_addr_d;
            out_valid_q   <= out_valid_d;
            out_q         <= out_d;
        end
    end

    // A redirect while a request is still pending must wait out that request in SQUASH.
    always_comb begin
        state_d = state_q;
        if (redirect) state_d = (req_valid && !i_instr_rsp.ready) ? SQUASH : FETCH;
        else case (state_q)
            FETCH:   state_d = !cap ? FETCH : i_instr_rsp.illegal ? FAULT : push ? FULL : FETCH;
            FULL:    state_d = pop ? FETCH : FULL;
            SQUASH:  state_d = done ? FETCH : SQUASH;
            default: state_d = FAULT;
        endcase
    end

    always_comb begin
        fetch_pc_d    = redirect ? i_s2_to_s1.branch_target_addr
                      : (cap && !i_instr_rsp.illegal) ? fetch_pc_q + PC_INCR : fetch_pc_q;
        squash_addr_d = state_q == SQUASH ? squash_addr_q : fetch_pc_q;
        out_valid_d   = redirect ? 1'b0 : load_out ? (skid_valid || cap) : out_valid_q;
        out_d         = load_out ? (skid_valid ? skid_entry : cap_entry) : out_q;
    end

    always_comb begin
        o_instr_req   = '{addr: state_q == SQUASH ? squash_addr_q : fetch_pc_q, valid: req_valid};
        o_s1_to_s2    = '{valid: out_valid_q, pc: out_q.pc, instr: out_q.instr};
        o_fetch_fault = out_valid_q && out_q.fault;
    end
endmodule

// File: tb/tb_core_fetch_ctrl.sv
// tb_core_fetch_ctrl: directed self-checking bench; the icache returns ~addr as instruction data.
module tb_core_fetch_ctrl;
    import core_pkg::*;

    logic           clk = 1'b0;
    logic           rst, rdy, ill, stall, br_en;
    word_t          br_tgt;
    mmu_instr_req_s req;
    mmu_instr_rsp_s rsp;
    s1_to_s2_s      s2;
    s2_to_s1_s      br;
    logic           fault;
    int             tests = 0;
    int             fails = 0;

    assign rsp = {~req.addr, rdy, ill};
    assign br  = {br_en, br_tgt};

    core_fetch_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_instr_req   (req),
        .i_instr_rsp   (rsp),
        .o_s1_to_s2    (s2),
        .o_fetch_fault (fault),
        .i_stall       (stall),
        .i_s2_to_s1    (br)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input word_t pc);
        chk({tag, "_valid"}, {31'd0, s2.valid}, 32'd1);
        chk({tag, "_pc"}, s2.pc, pc);
        chk({tag, "_instr"}, s2.instr, ~pc);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; ill = 1'b0; stall = 1'b0; br_en = 1'b0; br_tgt = '0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, s2.valid}, 32'd0);
        chk("rst_req_valid", {31'd0, req.valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_pc", s2.pc, 32'd0);
        rst = 1'b0; rdy = 1'b1;
        #1;
        chk("first_req_valid", {31'd0, req.valid}, 32'd1);
        chk("first_req_addr", req.addr, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("stream", 32'(4 * k));
            chk("stream_addr", req.addr, 32'(4 * k + 4));
        end
        rdy = 1'b0;
        tick();
        chk("lat_out_empty", {31'd0, s2.valid}, 32'd0);
        chk("lat_addr_hold1", req.addr, 32'd16);
        tick();
        chk("lat_out_empty2", {31'd0, s2.valid}, 32'd0);
        chk("lat_addr_hold2", req.addr, 32'd16);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk_out("lat_done", 32'd16);
        chk("lat_next_addr", req.addr, 32'd20);
        tick();
        chk("lat_no_dup", {31'd0, s2.valid}, 32'd0);
        rdy = 1'b1;
        tick();
        chk_out("pre_stall", 32'd20);
        stall = 1'b1;
        tick();
        chk_out("stall_hold", 32'd20);
        chk("full_req_low", {31'd0, req.valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_hold_pc", s2.pc, 32'd20);
            chk("full_req_still_low", {31'd0, req.valid}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk_out("skid_drain", 32'd24);
        chk("resume_req", {31'd0, req.valid}, 32'd1);
        chk("resume_addr", req.addr, 32'd28);
        tick();
        chk_out("after_resume", 32'd28);
        rdy = 1'b0;
        tick();
        chk("pre_redirect_empty", {31'd0, s2.valid}, 32'd0);
        br_en = 1'b1; br_tgt = 32'h100;
        tick();
        br_en = 1'b0;
        chk("squash_req_valid", {31'd0, req.valid}, 32'd1);
        chk("squash_old_addr", req.addr, 32'd32);
        chk("squash_out_empty", {31'd0, s2.valid}, 32'd0);
        tick();
        chk("squash_addr_hold", req.addr, 32'd32);
        rdy = 1'b1;
        tick();
        chk("squash_dropped", {31'd0, s2.valid}, 32'd0);
        chk("target_addr", req.addr, 32'h100);
        tick();
        chk_out("target_entry", 32'h100);
        br_en = 1'b1; br_tgt = 32'h200; stall = 1'b1;
        tick();
        br_en = 1'b0; stall = 1'b0;
        chk("redir_ready_drop", {31'd0, s2.valid}, 32'd0);
        chk("redir_ready_addr", req.addr, 32'h200);
        tick();
        chk_out("redir2_entry", 32'h200);
        ill = 1'b1;
        tick();
        ill = 1'b0;
        chk_out("fault_entry", 32'h204);
        chk("fault_flag", {31'd0, fault}, 32'd1);
        chk("fault_req_low", {31'd0, req.valid}, 32'd0);
        tick();
        chk("fault_consumed", {31'd0, s2.valid}, 32'd0);
        chk("fault_no_req", {31'd0, req.valid}, 32'd0);
        br_en = 1'b1; br_tgt = 32'h80;
        tick();
        br_en = 1'b0;
        chk("fault_redir_req", {31'd0, req.valid}, 32'd1);
        chk("fault_redir_addr", req.addr, 32'h80);
        tick();
        chk_out("resume_80", 32'h80);
        chk("resume_80_fault", {31'd0, fault}, 32'd0);
        br_en = 1'b1; br_tgt = 32'hFFFFFFFC;
        tick();
        br_en = 1'b0;
        chk("wrap_addr", req.addr, 32'hFFFFFFFC);
        tick();
        chk_out("wrap_entry", 32'hFFFFFFFC);
        chk("wrap_next_addr", req.addr, 32'd0);
        rdy = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_req_low", {31'd0, req.valid}, 32'd0);
        tick();
        chk("rst_mid_out", {31'd0, s2.valid}, 32'd0);
        chk("rst_mid_req", {31'd0, req.valid}, 32'd0);
        rst = 1'b0; rdy = 1'b1;
        #1;
        chk("restart_addr", req.addr, RESET_PC);
        chk("restart_req", {31'd0, req.valid}, 32'd1);
        tick();
        chk_out("restart_entry", RESET_PC);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_fetch_ctrl.md
Name: core_fetch_ctrl

Overview:
Stage-1 fetch sequencer of the LETC core. It owns the PC, drives the icache/MMU instruction request (mmu_instr_req_s / mmu_instr_rsp_s) and presents fetched instructions to s2 through s1_to_s2_s. It also applies s2 redirects (s2_to_s1_s), which includes squashing a request that is already in flight. A one-entry skid buffer decouples s2 stalls from the icache handshake.

Parameters:
RESET_PC, core_pkg::RESET_PC (32'h00000000), PC loaded on reset.

Ports:
i_clk  in  1  core clock.
i_rst  in  1  synchronous, active-high reset.
o_instr_req  out  64  mmu_instr_req_s; addr = fetch PC, valid = request (32'd1 / 32'd0).
i_instr_rsp  in  34  mmu_instr_rsp_s; data, ready (one-cycle completion), illegal.
o_s1_to_s2  out  65  s1_to_s2_s; registered valid/pc/instr to s2.
o_fetch_fault  out  1  qualifies o_s1_to_s2.valid; the entry's fetch returned illegal.
i_stall  in  1  s2 cannot accept; the output entry is held.
i_s2_to_s1  in  33  s2_to_s1_s; branch_en is a one-cycle redirect to branch_target_addr.

Behaviour:
- Reset values: fetch_pc = RESET_PC, state = FETCH, o_s1_to_s2.valid = 0, pc/instr = 0, o_fetch_fault = 0, skid empty, o_instr_req.valid = 0 during reset.
- Consume rule: the output entry is consumed at an edge where o_s1_to_s2.valid && !i_stall. On consume, the skid entry (if any) moves into the output register.
- Request rule:
  - o_instr_req.valid is high in FETCH and SQUASH only.
  - A request, once raised, holds addr stable and stays high until the edge with i_instr_rsp.ready (sticky, no cancel).
  - The icache may complete a request in the first cycle it is asserted. Minimum latency is reset release -> req valid next cycle -> output valid the cycle after ready.
- States:
  - FETCH: on ready with illegal = 0, capture {1, fetch_pc, data}. The capture goes to the output register if it is empty or being consumed, else to the skid. Then fetch_pc += 4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
    - If the skid is full after the capture, go to FULL (req deasserted).
    - Back-to-back: the next request is issued the cycle after ready.
  - FULL: no request. Return to FETCH when the skid drains, i.e. the request resumes the cycle after the consume.
  - FAULT: on ready with illegal = 1 in FETCH, capture the entry with fault = 1 and go to FAULT. fetch_pc is not advanced and no further requests are made until a redirect.
  - SQUASH: the in-flight request keeps asserting its old addr until ready. Its data is discarded, then go to FETCH.
- Redirect (branch_en = 1), evaluated with priority over stall and over capture:
  - fetch_pc <= branch_target_addr.
  - Output and skid are invalidated at that edge.
  - If a request is outstanding and ready = 0 that cycle, go to SQUASH; otherwise go to FETCH.
  - Ready coinciding with branch_en: the data is discarded and the target request starts next cycle.
  - A redirect arriving in SQUASH updates the target and stays in SQUASH.
  - A redirect arriving in FULL or FAULT goes directly to FETCH.
  - The target is used as given; misalignment checks are s2's job.
- Simultaneous events:
  - Consume and ready at the same edge: the new entry goes straight to the output register.
  - Stall and redirect: the redirect wins.
- Reset mid-operation: everything returns to reset values and the in-flight request is abandoned. The icache shares i_rst.
- Invariant: entries reach s2 in PC order with no duplicates, and nothing captured before a redirect is presented after it.

Decomposition:
- Add to core_pkg:
  - fetch_state_e {FETCH, FULL, SQUASH, FAULT}.
  - Constant PC_INCR = 32'd4.
  - Narrow mmu_instr_req_s.valid to logic (the current word_t width is a bug). After that change, o_instr_req becomes 33 bits.
- Sub-module: core_fetch_skid, a one-entry {pc, instr, fault} register with push/pop/flush.

Test Plan:
- Reset release, icache ready every cycle, no stall -> addrs 0,4,8,... on consecutive cycles; o_s1_to_s2 valid each cycle from cycle 2 with matching pc/instr.
- Ready with 3-cycle latency -> addr held stable for 3 cycles; exactly one entry per completion; no duplicate PCs.
- Stall for 5 cycles while fetching -> output holds pc=0x8; skid takes 0xC; req drops (FULL); after release, s2 sees 0x8, 0xC, 0x10 in order.
- Redirect to 0x100 while the request for 0x14 is outstanding (ready 2 cycles later) -> SQUASH keeps addr 0x14; its data is dropped; next request is 0x100; no 0x14 or 0x18 entry reaches s2.
- Ready with illegal at pc=0x20 -> entry with o_fetch_fault=1; no further requests; redirect to 0x80 resumes fetch at 0x80.
- fetch_pc=0xFFFFFFFC -> next addr 0x0; reset asserted mid-request -> req valid 0 and valid 0 the next cycle, then fetch restarts at RESET_PC.
